amo_responder: RTL and testbench

AMO_RESPONDER -- requirements
Module: amo_responder

---
 rtl/amo_responder.sv | 219 +++++++++++++++++++++
 tb/tb_amo_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_responder.sv
// Atomic-memory responder: AMO read-modify-write, LR/SC reservation and error response over a single-port SRAM.
// Optional LR/SC reservation timeout is built when macro LRSC_TIMEOUT_EN is defined.
module amo_responder #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_i,
  output logic                  ready_o,
  input  logic [1:0]            kind_i,
  input  logic [9:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  error_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  snoop_we_i,
  input  logic [ADDR_WIDTH-1:0] snoop_addr_i
);

  localparam logic [1:0] KIND_AMO = 2'b00;
  localparam logic [1:0] KIND_LR  = 2'b01;
  localparam logic [1:0] KIND_SC  = 2'b10;

  localparam logic [9:0] OP_NOP  = 10'b00_0000_0001;
  localparam logic [9:0] OP_SWAP = 10'b00_0000_0010;
  localparam logic [9:0] OP_ADD  = 10'b00_0000_0100;
  localparam logic [9:0] OP_XOR  = 10'b00_0000_1000;
  localparam logic [9:0] OP_AND  = 10'b00_0001_0000;
  localparam logic [9:0] OP_OR   = 10'b00_0010_0000;
  localparam logic [9:0] OP_MIN  = 10'b00_0100_0000;
  localparam logic [9:0] OP_MAX  = 10'b00_1000_0000;
  localparam logic [9:0] OP_MINU = 10'b01_0000_0000;
  localparam logic [9:0] OP_MAXU = 10'b10_0000_0000;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                state_r, state_next_s;
  logic [1:0]            kind_r;
  logic [9:0]            op_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic                  err_r, sc_fail_r;
  logic                  res_valid_r;
  logic [ADDR_WIDTH-3:0] res_addr_r;
  logic                  accept_s, req_err_s, onehot_s, sc_hit_s, lr_set_s, snoop_clr_s;
  logic [31:0]           amo_result_s;
`ifdef LRSC_TIMEOUT_EN
  logic [5:0]            res_cnt_r;
`endif

  function automatic logic [31:0] amo_alu(input logic [9:0] op, input logic [31:0] old,
                                          input logic [31:0] rs2);
    logic [31:0] res;
    case (op)
      OP_SWAP: res = rs2;
      OP_ADD:  res = old + rs2;
      OP_XOR:  res = old ^ rs2;
      OP_AND:  res = old & rs2;
      OP_OR:   res = old | rs2;
      OP_MIN:  res = ($signed(old) < $signed(rs2)) ? old : rs2;
      OP_MAX:  res = ($signed(old) > $signed(rs2)) ? old : rs2;
      OP_MINU: res = (old < rs2) ? old : rs2;
      OP_MAXU: res = (old > rs2) ? old : rs2;
      default: res = old;
    endcase
    return res;
  endfunction

  assign accept_s     = req_i && reset_n && (state_r == IDLE);
  assign onehot_s     = (op_i != 10'd0) && ((op_i & (op_i - 10'd1)) == 10'd0);
  assign lr_set_s     = (state_r == WAIT) && (kind_r == KIND_LR) && !err_r;
  // A snoop also kills a reservation that is being established in the same cycle.
  assign snoop_clr_s  = snoop_we_i &&
                        ((res_valid_r && (snoop_addr_i[ADDR_WIDTH-1:2] == res_addr_r)) ||
                         (lr_set_s && (snoop_addr_i[ADDR_WIDTH-1:2] == addr_r[ADDR_WIDTH-1:2])));
  assign sc_hit_s     = res_valid_r && !snoop_clr_s && (res_addr_r == addr_i[ADDR_WIDTH-1:2]);
  assign amo_result_s = amo_alu(op_r, mem_rdata_i, wdata_r);

  // Request legality decode
  always_comb begin
    req_err_s = 1'b0;
    if (addr_i[1:0] != 2'b00) begin
      req_err_s = 1'b1;
    end else if (kind_i == 2'b11) begin
      req_err_s = 1'b1;
    end else if ((kind_i == KIND_AMO) && (!onehot_s || (op_i == OP_NOP))) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE:    state_next_s = accept_s ? WAIT : IDLE;
      WAIT:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture at acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kind_r    <= 2'b00;
      op_r      <= 10'd0;
      addr_r    <= '0;
      wdata_r   <= 32'd0;
      err_r     <= 1'b0;
      sc_fail_r <= 1'b0;
    end else if (accept_s) begin
      kind_r    <= kind_i;
      op_r      <= op_i;
      addr_r    <= addr_i;
      wdata_r   <= wdata_i;
      err_r     <= req_err_s;
      sc_fail_r <= !sc_hit_s;
    end
  end

  // Reservation tracking; clears are ordered last so they win over a set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_r <= 1'b0;
      res_addr_r  <= '0;
`ifdef LRSC_TIMEOUT_EN
      res_cnt_r   <= 6'd0;
`endif
    end else begin
      if (accept_s && (req_err_s || (kind_i == KIND_SC))) begin
        res_valid_r <= 1'b0;
      end else if (lr_set_s) begin
        res_valid_r <= 1'b1;
        res_addr_r  <= addr_r[ADDR_WIDTH-1:2];
      end
`ifdef LRSC_TIMEOUT_EN
      if (lr_set_s) begin
        res_cnt_r <= 6'd0;
      end else if (res_valid_r) begin
        res_cnt_r <= res_cnt_r + 6'd1;
        if (res_cnt_r == 6'd63) res_valid_r <= 1'b0;
      end
`endif
      if (snoop_clr_s) res_valid_r <= 1'b0;
    end
  end

  // Output decode
  always_comb begin
    ready_o     = (state_r == IDLE);
    rvalid_o    = 1'b0;
    rdata_o     = 32'd0;
    error_o     = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'd0;
    case (state_r)
      IDLE: begin
        if (accept_s && !req_err_s) begin
          case (kind_i)
            KIND_AMO, KIND_LR: begin
              mem_en_o   = 1'b1;
              mem_addr_o = addr_i;
            end
            KIND_SC: begin
              if (sc_hit_s) begin
                mem_en_o    = 1'b1;
                mem_we_o    = 4'b1111;
                mem_addr_o  = addr_i;
                mem_wdata_o = wdata_i;
              end else begin
                mem_en_o = 1'b0;
              end
            end
            default: mem_en_o = 1'b0;
          endcase
        end else begin
          mem_en_o = 1'b0;
        end
      end
      WAIT: begin
        rvalid_o = 1'b1;
        error_o  = err_r;
        if (!err_r) begin
          case (kind_r)
            KIND_AMO: begin
              rdata_o     = mem_rdata_i;
              mem_en_o    = 1'b1;
              mem_we_o    = 4'b1111;
              mem_addr_o  = addr_r;
              mem_wdata_o = amo_result_s;
            end
            KIND_LR: rdata_o = mem_rdata_i;
            KIND_SC: rdata_o = {31'd0, sc_fail_r};
            default: rdata_o = 32'd0;
          endcase
        end else begin
          rdata_o = 32'd0;
        end
      end
      default: ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_amo_responder.sv
// Directed self-checking bench for amo_responder with a behavioural single-port SRAM.
module tb_amo_responder;

  localparam logic [1:0] K_AMO = 2'b00, K_LR = 2'b01, K_SC = 2'b10, K_RSV = 2'b11;
  localparam logic [9:0] O_NOP = 10'h001, O_SWAP = 10'h002, O_ADD = 10'h004, O_XOR = 10'h008,
                         O_AND = 10'h010, O_OR = 10'h020, O_MIN = 10'h040, O_MAX = 10'h080,
                         O_MINU = 10'h100, O_MAXU = 10'h200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  kind_i = 2'b00;
  logic [9:0]  op_i = 10'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        snoop_we_i = 1'b0;
  logic [31:0] snoop_addr_i = 32'd0;
  logic [31:0] mem_rdata_i;
  logic        ready_o, rvalid_o, error_o, mem_en_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_we_o;

  logic [31:0] sram [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_data = 32'd0;

  int checks = 0;
  int errors = 0;

  logic        o_ready_n, o_en_n, o_ready_n1, o_rvalid_n1, o_err_n1, o_en_n1, o_ready_n2, o_rvalid_n2;
  logic [3:0]  o_we_n, o_we_n1;
  logic [31:0] o_wdata_n, o_rdata_n1, o_wdata_n1;

  amo_responder #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .ready_o(ready_o), .kind_i(kind_i),
    .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .error_o(error_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .snoop_we_i(snoop_we_i),
    .snoop_addr_i(snoop_addr_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) sram[pre_idx] <= pre_data;
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) sram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      mem_rdata_i <= sram[mem_addr_o[9:2]];
    end
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // One request; operands are scrambled during WAIT to show they are ignored.
  task automatic issue(input logic [1:0] k, input logic [9:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic snp, input logic [31:0] sa);
    @(posedge clk); #1;
    req_i = 1'b1; kind_i = k; op_i = op; addr_i = a; wdata_i = d;
    snoop_we_i = snp; snoop_addr_i = sa;
    @(negedge clk);
    o_ready_n = ready_o; o_en_n = mem_en_o; o_we_n = mem_we_o; o_wdata_n = mem_wdata_o;
    @(posedge clk); #1;
    snoop_we_i = 1'b0; kind_i = ~k; op_i = 10'h3FF; addr_i = ~a; wdata_i = ~d;
    @(negedge clk);
    o_ready_n1 = ready_o; o_rvalid_n1 = rvalid_o; o_rdata_n1 = rdata_o; o_err_n1 = error_o;
    o_en_n1 = mem_en_o; o_we_n1 = mem_we_o; o_wdata_n1 = mem_wdata_o;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(negedge clk);
    o_ready_n2 = ready_o; o_rvalid_n2 = rvalid_o;
  endtask

  task automatic test_reset;
    checks++;
    if (ready_o !== 1'b1 || rvalid_o !== 1'b0 || rdata_o !== 32'd0 || error_o !== 1'b0 ||
        mem_en_o !== 1'b0 || mem_we_o !== 4'b0000 || mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b rvalid=%b rdata=%h err=%b en=%b we=%b addr=%h wdata=%h, want 1 0 0 0 0 0 0 0",
               ready_o, rvalid_o, rdata_o, error_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
  endtask

  task automatic test_amo_add;
    preload(8'h40, 32'd5);
    issue(K_AMO, O_ADD, 32'h100, 32'd7, 1'b0, 32'd0);
    checks++;
    if (o_ready_n !== 1'b1 || o_en_n !== 1'b1 || o_we_n !== 4'b0000) begin
      errors++;
      $display("FAIL add_read: got ready=%b en=%b we=%b, want 1 1 0000", o_ready_n, o_en_n, o_we_n);
    end
    checks++;
    if (o_ready_n1 !== 1'b0 || o_rvalid_n1 !== 1'b1 || o_rdata_n1 !== 32'd5 || o_err_n1 !== 1'b0 ||
        o_we_n1 !== 4'b1111 || o_wdata_n1 !== 32'd12) begin
      errors++;
      $display("FAIL add_resp: got ready=%b rvalid=%b rdata=%h err=%b we=%b wdata=%h, want 0 1 5 0 1111 c",
               o_ready_n1, o_rvalid_n1, o_rdata_n1, o_err_n1, o_we_n1, o_wdata_n1);
    end
    checks++;
    if (sram[8'h40] !== 32'd12 || o_ready_n2 !== 1'b1 || o_rvalid_n2 !== 1'b0) begin
      errors++;
      $display("FAIL add_done: got sram=%h ready=%b rvalid=%b, want c 1 0", sram[8'h40], o_ready_n2, o_rvalid_n2);
    end
  endtask

  task automatic test_amo_ops;
    logic [9:0]  ops  [9];
    logic [31:0] init [9];
    logic [31:0] rs2  [9];
    logic [31:0] expv [9];
    ops[0] = O_SWAP; init[0] = 32'h1234_5678; rs2[0] = 32'hCAFE_F00D; expv[0] = 32'hCAFE_F00D;
    ops[1] = O_ADD;  init[1] = 32'hFFFF_FFFF; rs2[1] = 32'd2;         expv[1] = 32'd1;
    ops[2] = O_XOR;  init[2] = 32'hF0F0_F0F0; rs2[2] = 32'hFF00_FF00; expv[2] = 32'h0FF0_0FF0;
    ops[3] = O_AND;  init[3] = 32'hF0F0_F0F0; rs2[3] = 32'hFF00_FF00; expv[3] = 32'hF000_F000;
    ops[4] = O_OR;   init[4] = 32'hF0F0_F0F0; rs2[4] = 32'hFF00_FF00; expv[4] = 32'hFFF0_FFF0;
    ops[5] = O_MIN;  init[5] = 32'hFFFF_FFFF; rs2[5] = 32'd1;         expv[5] = 32'hFFFF_FFFF;
    ops[6] = O_MAX;  init[6] = 32'hFFFF_FFFF; rs2[6] = 32'd1;         expv[6] = 32'd1;
    ops[7] = O_MINU; init[7] = 32'hFFFF_FFFF; rs2[7] = 32'd1;         expv[7] = 32'd1;
    ops[8] = O_MAXU; init[8] = 32'hFFFF_FFFF; rs2[8] = 32'd1;         expv[8] = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) begin
      preload(8'h10, init[i]);
      issue(K_AMO, ops[i], 32'h40, rs2[i], 1'b0, 32'd0);
      checks++;
      if (o_rdata_n1 !== init[i] || o_we_n1 !== 4'b1111 || o_wdata_n1 !== expv[i] || sram[8'h10] !== expv[i]) begin
        errors++;
        $display("FAIL amo_op%0d: got rdata=%h we=%b wdata=%h sram=%h, want rdata=%h we=1111 result=%h",
                 i, o_rdata_n1, o_we_n1, o_wdata_n1, sram[8'h10], init[i], expv[i]);
      end
    end
  endtask

  task automatic test_lrsc;
    preload(8'h20, 32'h55);
    issue(K_LR, 10'd0, 32'h80, 32'd0, 1'b0, 32'd0);
    checks++;
    if (o_en_n !== 1'b1 || o_we_n !== 4'b0000 || o_rdata_n1 !== 32'h55 || o_we_n1 !== 4'b0000 || o_err_n1 !== 1'b0) begin
      errors++;
      $display("FAIL lr: got en=%b we=%b rdata=%h we1=%b err=%b, want 1 0000 55 0000 0",
               o_en_n, o_we_n, o_rdata_n1, o_we_n1, o_err_n1);
    end
    issue(K_SC, 10'd0, 32'h80, 32'hAA, 1'b0, 32'd0);
    checks++;
    if (o_en_n !== 1'b1 || o_we_n !== 4'b1111 || o_wdata_n !== 32'hAA || o_rdata_n1 !== 32'd0 ||
        o_we_n1 !== 4'b0000 || sram[8'h20] !== 32'hAA) begin
      errors++;
      $display("FAIL sc_ok: got en=%b we=%b wdata=%h rdata=%h we1=%b sram=%h, want 1 1111 aa 0 0000 aa",
               o_en_n, o_we_n, o_wdata_n, o_rdata_n1, o_we_n1, sram[8'h20]);
    end
    issue(K_SC, 10'd0, 32'h80, 32'hBB, 1'b0, 32'd0);
    checks++;
    if (o_en_n !== 1'b0 || o_rdata_n1 !== 32'd1 || o_en_n1 !== 1'b0 || sram[8'h20] !== 32'hAA) begin
      errors++;
      $display("FAIL sc_again: got en=%b rdata=%h en1=%b sram=%h, want 0 1 0 aa",
               o_en_n, o_rdata_n1, o_en_n1, sram[8'h20]);
    end
  endtask

  task automatic test_snoop;
    issue(K_LR, 10'd0, 32'h80, 32'd0, 1'b0, 32'd0);
    issue(K_SC, 10'd0, 32'h80, 32'h77, 1'b1, 32'h82);
    checks++;
    if (o_rdata_n1 !== 32'd1 || o_we_n !== 4'b0000 || o_en_n !== 1'b0 || sram[8'h20] !== 32'hAA) begin
      errors++;
      $display("FAIL sc_snoop: got rdata=%h we=%b en=%b sram=%h, want 1 0000 0 aa",
               o_rdata_n1, o_we_n, o_en_n, sram[8'h20]);
    end
  endtask

  task automatic test_errors;
    logic [1:0]  ks [6];
    logic [9:0]  os [6];
    logic [31:0] as [6];
    ks[0] = K_AMO; os[0] = O_SWAP;         as[0] = 32'h102;
    ks[1] = K_RSV; os[1] = O_SWAP;         as[1] = 32'h100;
    ks[2] = K_AMO; os[2] = 10'd0;          as[2] = 32'h100;
    ks[3] = K_AMO; os[3] = O_NOP;          as[3] = 32'h100;
    ks[4] = K_AMO; os[4] = O_SWAP | O_ADD; as[4] = 32'h100;
    ks[5] = K_LR;  os[5] = 10'd0;          as[5] = 32'h81;
    for (int i = 0; i < 6; i++) begin
      issue(ks[i], os[i], as[i], 32'h1234, 1'b0, 32'd0);
      checks++;
      if (o_en_n !== 1'b0 || o_en_n1 !== 1'b0 || o_rvalid_n1 !== 1'b1 || o_err_n1 !== 1'b1 || o_rdata_n1 !== 32'd0) begin
        errors++;
        $display("FAIL err_vec%0d: got en=%b en1=%b rvalid=%b err=%b rdata=%h, want 0 0 1 1 0",
                 i, o_en_n, o_en_n1, o_rvalid_n1, o_err_n1, o_rdata_n1);
      end
    end
    issue(K_LR, 10'd0, 32'h80, 32'd0, 1'b0, 32'd0);
    issue(K_AMO, O_SWAP, 32'h102, 32'd0, 1'b0, 32'd0);
    issue(K_SC, 10'd0, 32'h80, 32'h99, 1'b0, 32'd0);
    checks++;
    if (o_rdata_n1 !== 32'd1 || o_en_n !== 1'b0) begin
      errors++;
      $display("FAIL err_clears_res: got rdata=%h en=%b, want 1 0", o_rdata_n1, o_en_n);
    end
  endtask

  task automatic test_reset_in_wait;
    logic saw_rvalid = 1'b0;
    issue(K_LR, 10'd0, 32'h80, 32'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    req_i = 1'b1; kind_i = K_AMO; op_i = O_ADD; addr_i = 32'h100; wdata_i = 32'd1;
    @(posedge clk); #1;
    req_i = 1'b0; reset_n = 1'b0;
    #1;
    checks++;
    if (rvalid_o !== 1'b0 || mem_we_o !== 4'b0000 || mem_en_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort: got rvalid=%b we=%b en=%b ready=%b, want 0 0000 0 1",
               rvalid_o, mem_we_o, mem_en_o, ready_o);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rvalid_o) saw_rvalid = 1'b1;
    end
    checks++;
    if (saw_rvalid !== 1'b0 || sram[8'h40] !== 32'd12) begin
      errors++;
      $display("FAIL reset_no_write: got rvalid_seen=%b sram=%h, want 0 c", saw_rvalid, sram[8'h40]);
    end
    issue(K_SC, 10'd0, 32'h80, 32'h66, 1'b0, 32'd0);
    checks++;
    if (o_rdata_n1 !== 32'd1 || o_en_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_res: got rdata=%h en=%b, want 1 0", o_rdata_n1, o_en_n);
    end
  endtask

  task automatic test_timeout;
    issue(K_LR, 10'd0, 32'h80, 32'd0, 1'b0, 32'd0);
    repeat (10) @(posedge clk);
    issue(K_SC, 10'd0, 32'h80, 32'h11, 1'b0, 32'd0);
    checks++;
    if (o_rdata_n1 !== 32'd0 || sram[8'h20] !== 32'h11) begin
      errors++;
      $display("FAIL sc_short_idle: got rdata=%h sram=%h, want 0 11", o_rdata_n1, sram[8'h20]);
    end
    issue(K_LR, 10'd0, 32'h80, 32'd0, 1'b0, 32'd0);
    repeat (64) @(posedge clk);
    issue(K_SC, 10'd0, 32'h80, 32'h22, 1'b0, 32'd0);
`ifdef LRSC_TIMEOUT_EN
    checks++;
    if (o_rdata_n1 !== 32'd1 || sram[8'h20] !== 32'h11) begin
      errors++;
      $display("FAIL sc_timeout: got rdata=%h sram=%h, want 1 11", o_rdata_n1, sram[8'h20]);
    end
`else
    checks++;
    if (o_rdata_n1 !== 32'd0 || sram[8'h20] !== 32'h22) begin
      errors++;
      $display("FAIL sc_persist: got rdata=%h sram=%h, want 0 22", o_rdata_n1, sram[8'h20]);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'd0;
    mem_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset;
    #1 reset_n = 1'b1;
    test_amo_add;
    test_amo_ops;
    test_lrsc;
    test_snoop;
    test_errors;
    test_reset_in_wait;
    test_timeout;
    @(negedge clk);
    test_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
